// File: rtl/legv8_mem_pkg.sv
// Shared types and constants for the LEGv8 data-memory slice.
// Word geometry, wait-counter width and the responder FSM state encoding.
package legv8_mem_pkg;

   localparam int unsigned LEGV8_WORD_BYTES = 8;
   localparam int unsigned LEGV8_WORD_BITS  = 64;
   localparam int unsigned LEGV8_OFS_BITS   = $clog2(LEGV8_WORD_BYTES);
   localparam int unsigned LEGV8_WAIT_CNT_W = 4;

   typedef logic [LEGV8_WORD_BITS-1:0] legv8_word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } legv8_dmem_state_t;

endpackage

// File: rtl/legv8_dmem_responder_if.sv
// Processor-to-data-memory bus: request from the processor, response from memory.
interface legv8_dmem_responder_if;
   import legv8_mem_pkg::*;

   legv8_word_t address;
   legv8_word_t data;
   logic        M_Write;
   logic        En_Ram;
   legv8_word_t rdata;
   logic        ready;
   logic        busy;
   logic        error;

   modport master (
      output address, data, M_Write, En_Ram,
      input  rdata, ready, busy, error
   );

   modport slave (
      input  address, data, M_Write, En_Ram,
      output rdata, ready, busy, error
   );

endinterface

// File: rtl/legv8_dmem_array.sv
// Single-port synchronous 64-bit word RAM with write enable and a registered read port.
// Storage is never reset.
module legv8_dmem_array
   import legv8_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clock,
   input  logic                           i_we,
   input  logic                           i_re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  legv8_word_t                    i_wdata,
   output legv8_word_t                    o_rdata
);

   legv8_word_t r_mem [DEPTH_WORDS];
   legv8_word_t r_q;

   always_ff @(posedge clock) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_q <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/legv8_dmem_responder.sv
// LEGv8 data-memory responder: captures a bus request, waits WAIT_STATES cycles, accesses the array.
// Optional misalignment error: define LEGV8_DMEM_ALIGN_CHECK_EN.
module legv8_dmem_responder
   import legv8_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   legv8_dmem_responder_if.slave  bus
);

   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned HI_LSB = IDX_W + LEGV8_OFS_BITS;
   localparam logic [LEGV8_WAIT_CNT_W-1:0] LP_CNT_LOAD =
      (WAIT_STATES == 0) ? '0 : LEGV8_WAIT_CNT_W'(WAIT_STATES - 1);

   legv8_dmem_state_t              r_state;
   legv8_dmem_state_t              w_state_nxt;
   logic [LEGV8_WAIT_CNT_W-1:0]    r_cnt;
   logic [63:LEGV8_OFS_BITS]       r_addr;
   legv8_word_t                    r_data;
   logic                           r_write;
   logic                           r_error;
   logic                           r_rd_zero;

   logic                           w_idle;
   logic                           w_capture;
   logic                           w_enter_resp;
   logic [63:LEGV8_OFS_BITS]       w_acc_addr;
   legv8_word_t                    w_acc_wdata;
   logic                           w_acc_write;
   logic [IDX_W-1:0]               w_acc_idx;
   logic                           w_acc_oor;
   logic                           w_acc_mis;
   logic                           w_err;
   logic                           w_we;
   logic                           w_re;
   legv8_word_t                    w_q;

   assign w_idle       = (r_state == IDLE);
   assign w_capture    = w_idle & bus.En_Ram;
   assign w_enter_resp = (w_capture & (WAIT_STATES == 0)) | ((r_state == WAIT) & (r_cnt == '0));

   // With zero wait states the access shares the capture edge, so it must use the live bus
   assign w_acc_addr  = w_idle ? bus.address[63:LEGV8_OFS_BITS] : r_addr;
   assign w_acc_wdata = w_idle ? bus.data : r_data;
   assign w_acc_write = w_idle ? bus.M_Write : r_write;
   assign w_acc_idx   = w_acc_addr[HI_LSB-1:LEGV8_OFS_BITS];
   assign w_acc_oor   = |w_acc_addr[63:HI_LSB];

`ifdef LEGV8_DMEM_ALIGN_CHECK_EN
   logic r_mis;
   assign w_acc_mis = w_idle ? |bus.address[LEGV8_OFS_BITS-1:0] : r_mis;
`else
   assign w_acc_mis = 1'b0;
`endif

   assign w_err = w_acc_oor | w_acc_mis;
   assign w_we  = reset & w_enter_resp &  w_acc_write & ~w_err;
   assign w_re  = reset & w_enter_resp & ~w_acc_write & ~w_err;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.En_Ram) w_state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
         WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ready = (r_state == RESP);
      bus.busy  = (r_state != IDLE);
      bus.error = r_error;
      bus.rdata = r_rd_zero ? '0 : w_q;
   end

   always_ff @(posedge clock) begin
      if (w_capture) begin
         r_addr  <= bus.address[63:LEGV8_OFS_BITS];
         r_data  <= bus.data;
         r_write <= bus.M_Write;
`ifdef LEGV8_DMEM_ALIGN_CHECK_EN
         r_mis   <= |bus.address[LEGV8_OFS_BITS-1:0];
`endif
      end
   end

   // r_rd_zero masks the array read register after reset or a faulted read
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_error   <= 1'b0;
         r_rd_zero <= 1'b1;
      end else begin
         r_error <= w_enter_resp & w_err;
         if (w_enter_resp & ~w_acc_write) begin
            r_rd_zero <= w_err;
         end
         if (w_capture & (WAIT_STATES != 0)) begin
            r_cnt <= LP_CNT_LOAD;
         end else if ((r_state == WAIT) & (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   legv8_dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clock   (clock),
      .i_we    (w_we),
      .i_re    (w_re),
      .i_addr  (w_acc_idx),
      .i_wdata (w_acc_wdata),
      .o_rdata (w_q)
   );

endmodule
